sdc_data_framer: RTL and testbench

Parametrised bit/byte sequencer for the SD-card write datapath; next generation of the single-block data counter. Frames one or more data blocks on a 1- or 4-bit DAT bus (start bit, payload, CRC, end bit, card-busy wait) and emits the load/shift/byte/block/CRC strobes that drive the parallel-to-serial shifter and CRC16 generators. Sits between the SD write controller (which issues `start`) and the per-line shift/CRC logic; advances only on the SD bit-slot enable.

---
 rtl/sdc_pkg.sv | 27 ++
 rtl/sdc_slot_counter.sv | 25 ++
 rtl/sdc_data_framer.sv | 176 +++++++++++++++++
 tb/tb_sdc_data_framer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// sdc_pkg: shared definitions for the SD-card DAT write framer.
//   sdc_state_t     - framer phase encoding
//   slots_per_byte  - bit slots needed to move one byte over the DAT bus
//   data_slots      - payload bit slots per block
//   CRC_BITS_DEF    - CRC16 bits per DAT line
package sdc_pkg;

    localparam int CRC_BITS_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_CRC,
        S_END,
        S_WAITBUSY
    } sdc_state_t;

    function automatic int slots_per_byte(input int bus_width);
        return 8 / bus_width;
    endfunction

    function automatic int data_slots(input int block_bytes, input int bus_width);
        return block_bytes * slots_per_byte(bus_width);
    endfunction

endpackage

// File: rtl/sdc_slot_counter.sv
// sdc_slot_counter: bit-slot counter shared by the DATA, CRC and busy-wait phases.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - increment this cycle
//   clr        - synchronous clear, wins over en
//   q          - current slot index
module sdc_slot_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + W'(1);
    end

endmodule

// File: rtl/sdc_data_framer.sv
// sdc_data_framer: frames one or more data blocks on a 1/4-bit SD DAT bus
// (start bit, payload, CRC, end bit, card-busy wait) and emits the strobes
// for the parallel-to-serial shifter and the per-line CRC16 generators.
// Every step is qualified by the bit-slot enable `count`.
//   clk, resetCounter        - clock, asynchronous active-low reset
//   start, numBlocks         - request and block count (0 means 1), IDLE only
//   count, cardBusy, abort   - slot enable, DAT0 busy, synchronous cancel
//   load, shift, bytes       - shifter strobes
//   block, endCRC            - last payload / last CRC slot of a block
//   startBit, crcPhase, endBit, busy - phase indications (state only)
//   blockIdx                 - 0-based index of the block being sent
//   done, aborted            - registered one-cycle completion pulses
module sdc_data_framer
    import sdc_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int BUS_WIDTH   = 1,
    parameter int CRC_BITS    = CRC_BITS_DEF,
    parameter int NBLK_W      = 8
) (
    input  logic              clk,
    input  logic              resetCounter,
    input  logic              start,
    input  logic [NBLK_W-1:0] numBlocks,
    input  logic              count,
    input  logic              cardBusy,
    input  logic              abort,
    output logic              load,
    output logic              shift,
    output logic              bytes,
    output logic              startBit,
    output logic              crcPhase,
    output logic              endBit,
    output logic              block,
    output logic              endCRC,
    output logic [NBLK_W-1:0] blockIdx,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int SPB      = slots_per_byte(BUS_WIDTH);
    localparam int DSLOTS   = data_slots(BLOCK_BYTES, BUS_WIDTH);
    localparam int SLOT_MAX = (DSLOTS > CRC_BITS) ? DSLOTS : CRC_BITS;
    localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

    localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(DSLOTS - 1);
    localparam logic [SLOT_W-1:0] CRC_LAST  = SLOT_W'(CRC_BITS - 1);
    localparam logic [SLOT_W-1:0] BYTE_MASK = SLOT_W'(SPB - 1);

    sdc_state_t        state, state_n;
    logic [SLOT_W-1:0] slot;
    logic              cnt_en, cnt_clr;
    logic [NBLK_W-1:0] last_idx;
    logic              latch, idx_inc, done_n, aborted_n;
    logic              last_data, byte_end, crc_last;

    sdc_slot_counter #(.W(SLOT_W)) u_slot (
        .clk   (clk),
        .rst_n (resetCounter),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .q     (slot)
    );

    assign last_data = (slot == DATA_LAST);
    assign byte_end  = ((slot & BYTE_MASK) == BYTE_MASK);
    assign crc_last  = (slot == CRC_LAST);

    assign startBit = (state == S_START);
    assign crcPhase = (state == S_CRC);
    assign endBit   = (state == S_END);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_n   = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        latch     = 1'b0;
        idx_inc   = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        bytes     = 1'b0;
        block     = 1'b0;
        endCRC    = 1'b0;
        // abort overrides everything, including a coincident count
        if (state != S_IDLE && abort) begin
            state_n   = S_IDLE;
            cnt_clr   = 1'b1;
            aborted_n = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_clr = 1'b1;
                    if (start) begin
                        latch   = 1'b1;
                        state_n = S_START;
                    end
                end
                S_START: begin
                    load = count;   // first payload byte goes in with the start bit
                    if (count) begin
                        cnt_clr = 1'b1;
                        state_n = S_DATA;
                    end
                end
                S_DATA: if (count) begin
                    shift = 1'b1;
                    bytes = byte_end;
                    // the byte after the final one belongs to no block
                    load  = byte_end && !last_data;
                    block = last_data;
                    if (last_data) begin
                        cnt_clr = 1'b1;
                        state_n = S_CRC;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_CRC: if (count) begin
                    endCRC = crc_last;
                    if (crc_last) begin
                        cnt_clr = 1'b1;
                        state_n = S_END;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_END: if (count) begin
                    cnt_clr = 1'b1;
                    state_n = S_WAITBUSY;
                end
                S_WAITBUSY: if (count) begin
                    // slot saturates at 1: the first counted slot only opens the
                    // card response window, release is honoured from the second on
                    if (slot != '0 && !cardBusy) begin
                        cnt_clr = 1'b1;
                        if (blockIdx == last_idx) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            idx_inc = 1'b1;
                            state_n = S_START;
                        end
                    end else if (slot == '0) begin
                        cnt_en = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetCounter) begin
        if (!resetCounter) begin
            state    <= S_IDLE;
            blockIdx <= '0;
            last_idx <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= done_n;
            aborted <= aborted_n;
            if (latch) begin
                blockIdx <= '0;
                last_idx <= (numBlocks == '0) ? '0 : numBlocks - NBLK_W'(1);
            end else if (idx_inc) begin
                blockIdx <= blockIdx + NBLK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdc_data_framer.sv
// Scoreboard bench for sdc_data_framer: two instances (1-bit and 4-bit bus),
// one selected for observation at a time. Stimulus pushes an expected
// transaction summary; the monitor accumulates strobe activity and compares
// when done/aborted pulses or reset is applied.
`timescale 1ns/1ps
module tb_sdc_data_framer;

    localparam int NBLK_W = 8;

    typedef struct {
        int kind;       // 0 done, 1 aborted, 2 reset
        int loads;
        int shifts;
        int nbytes;
        int blocks;
        int endcrcs;
        int crcs;       // counted CRC slots
        int blk_slot;   // slot of first block strobe, START slot = 1
        int ecrc_slot;  // slot of first endCRC strobe
        int gap;        // counted slots from last END to completion, -1 = skip
        int nstarts;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetCounter, start, sel, abort;
    logic [NBLK_W-1:0] numBlocks;
    logic              count = 1'b1;
    logic              cardBusy = 1'b0;
    int                cmode, inject;

    logic load_a, shift_a, bytes_a, startBit_a, crcPhase_a, endBit_a, block_a, endCRC_a, busy_a, done_a, aborted_a;
    logic load_b, shift_b, bytes_b, startBit_b, crcPhase_b, endBit_b, block_b, endCRC_b, busy_b, done_b, aborted_b;
    logic [NBLK_W-1:0] idx_a, idx_b, m_idx;
    logic [10:0] ov_a, ov_b, ov;
    logic m_load, m_shift, m_bytes, m_startBit, m_crcPhase, m_endBit, m_block, m_endCRC, m_busy, m_done, m_aborted;

    sdc_data_framer #(.BLOCK_BYTES(512), .BUS_WIDTH(1), .CRC_BITS(16), .NBLK_W(NBLK_W)) u_dut1 (
        .clk(clk), .resetCounter(resetCounter), .start(start && !sel), .numBlocks(numBlocks),
        .count(count), .cardBusy(cardBusy), .abort(abort),
        .load(load_a), .shift(shift_a), .bytes(bytes_a), .startBit(startBit_a), .crcPhase(crcPhase_a),
        .endBit(endBit_a), .block(block_a), .endCRC(endCRC_a), .blockIdx(idx_a), .busy(busy_a),
        .done(done_a), .aborted(aborted_a));

    sdc_data_framer #(.BLOCK_BYTES(512), .BUS_WIDTH(4), .CRC_BITS(16), .NBLK_W(NBLK_W)) u_dut4 (
        .clk(clk), .resetCounter(resetCounter), .start(start && sel), .numBlocks(numBlocks),
        .count(count), .cardBusy(cardBusy), .abort(abort),
        .load(load_b), .shift(shift_b), .bytes(bytes_b), .startBit(startBit_b), .crcPhase(crcPhase_b),
        .endBit(endBit_b), .block(block_b), .endCRC(endCRC_b), .blockIdx(idx_b), .busy(busy_b),
        .done(done_b), .aborted(aborted_b));

    assign ov_a = {load_a, shift_a, bytes_a, startBit_a, crcPhase_a, endBit_a, block_a, endCRC_a, busy_a, done_a, aborted_a};
    assign ov_b = {load_b, shift_b, bytes_b, startBit_b, crcPhase_b, endBit_b, block_b, endCRC_b, busy_b, done_b, aborted_b};
    assign ov    = sel ? ov_b : ov_a;
    assign m_idx = sel ? idx_b : idx_a;
    assign {m_load, m_shift, m_bytes, m_startBit, m_crcPhase, m_endBit, m_block, m_endCRC, m_busy, m_done, m_aborted} = ov;

    rec_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic rec_t mk(input int kind, input int loads, input int shifts, input int nbytes,
                                input int blocks, input int endcrcs, input int crcs, input int blk_slot,
                                input int ecrc_slot, input int gap, input int nstarts);
        rec_t r;
        r.kind = kind; r.loads = loads; r.shifts = shifts; r.nbytes = nbytes;
        r.blocks = blocks; r.endcrcs = endcrcs; r.crcs = crcs; r.blk_slot = blk_slot;
        r.ecrc_slot = ecrc_slot; r.gap = gap; r.nstarts = nstarts;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_rec(input rec_t a, input rec_t e);
        chk("kind", a.kind, e.kind);
        chk("load_count", a.loads, e.loads);
        chk("shift_count", a.shifts, e.shifts);
        chk("bytes_count", a.nbytes, e.nbytes);
        chk("block_count", a.blocks, e.blocks);
        chk("endcrc_count", a.endcrcs, e.endcrcs);
        chk("crc_slots", a.crcs, e.crcs);
        chk("block_slot", a.blk_slot, e.blk_slot);
        chk("endcrc_slot", a.ecrc_slot, e.ecrc_slot);
        if (e.gap >= 0) chk("busy_gap", a.gap, e.gap);
        chk("start_count", a.nstarts, e.nstarts);
    endtask

    // monitor: accumulate observed activity, compare on completion or reset
    initial begin : monitor
        rec_t a, e;
        int   sl, last_end, viol;
        bit   in_rst;
        a = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sl = 0; last_end = 0; viol = 0; in_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetCounter) begin
                if (!in_rst) begin
                    in_rst = 1'b1;
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_reset_event (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        a.kind = 2;
                        a.gap  = sl - last_end;
                        cmp_rec(a, e);
                        chk("reset_outputs", int'({ov_a, ov_b}), 0);
                        chk("reset_blockidx", int'({idx_a, idx_b}), 0);
                        chk("violations", viol, 0);
                    end
                    a = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    sl = 0; last_end = 0; viol = 0;
                end
            end else begin
                in_rst = 1'b0;
                if (m_busy && count) sl++;
                if (m_startBit && count) begin
                    if (int'(m_idx) != a.nstarts) viol++;
                    a.nstarts++;
                end
                if (m_endBit && count) last_end = sl;
                if ((m_load || m_shift || m_bytes || m_block || m_endCRC) && (!count || abort)) viol++;
                a.loads   += int'(m_load);
                a.shifts  += int'(m_shift);
                a.nbytes  += int'(m_bytes);
                a.blocks  += int'(m_block);
                a.endcrcs += int'(m_endCRC);
                a.crcs    += int'(m_crcPhase && count);
                if (m_block && a.blk_slot == 0) a.blk_slot = sl;
                if (m_endCRC && a.ecrc_slot == 0) a.ecrc_slot = sl;
                if (m_done || m_aborted) begin
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_completion done=%0d aborted=%0d (t=%0t)", m_done, m_aborted, $time);
                    end else begin
                        e = sb.pop_front();
                        a.kind = m_aborted ? 1 : 0;
                        a.gap  = sl - last_end;
                        cmp_rec(a, e);
                        chk("busy_after", int'(m_busy), 0);
                        chk("violations", viol, 0);
                    end
                    a = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    sl = 0; last_end = 0; viol = 0;
                end
            end
        end
    end

    // slot-enable and card-busy driver: count pattern by cmode, cardBusy held
    // for 10 counted slots after every END when inject is set
    initial begin : driver
        int ph, bleft;
        bit saw_end;
        ph = 0; bleft = 0;
        forever begin
            @(negedge clk);
            saw_end = m_endBit && count && resetCounter;
            @(posedge clk); #1;
            if (saw_end && inject != 0) bleft = 10;
            ph = (ph == 2) ? 0 : ph + 1;
            count = (cmode == 0) || (ph == 0);
            if (bleft > 0) begin
                cardBusy = 1'b1;
                if (count) bleft--;
            end else begin
                cardBusy = 1'b0;
            end
        end
    end

    task automatic kick(input logic [NBLK_W-1:0] n);
        start = 1'b1; numBlocks = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_done || m_aborted) break;
        end
        if (i == budget) begin
            vectors++; miscompares++;
            $display("FAIL timeout waiting for done/aborted after %0d cycles", budget);
        end
        @(posedge clk); #1;
    endtask

    initial begin : main
        resetCounter = 1'b0; start = 1'b0; sel = 1'b0; abort = 1'b0;
        numBlocks = 8'd1; cmode = 0; inject = 0;
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0));
        repeat (3) @(posedge clk);
        #1 resetCounter = 1'b1;
        @(posedge clk); #1;

        // single block, 1-bit bus, count always high
        sb.push_back(mk(0, 512, 4096, 512, 1, 1, 16, 4097, 4113, 2, 1));
        kick(8'd1);
        wait_end(20000);

        // 4-bit bus: two slots per byte
        sel = 1'b1;
        sb.push_back(mk(0, 512, 1024, 512, 1, 1, 16, 1025, 1041, 2, 1));
        kick(8'd1);
        wait_end(20000);
        sel = 1'b0;
        @(posedge clk); #1;

        // count 1-in-3: same totals and slot positions in counted slots
        cmode = 1;
        sb.push_back(mk(0, 512, 4096, 512, 1, 1, 16, 4097, 4113, 2, 1));
        kick(8'd1);
        wait_end(20000);
        cmode = 0;

        // three blocks, card busy for 10 slots after each END
        inject = 1;
        sb.push_back(mk(0, 1536, 12288, 1536, 3, 3, 48, 4097, 4113, 11, 3));
        kick(8'd3);
        wait_end(20000);
        inject = 0;

        // abort with count at DATA slot 100
        sb.push_back(mk(1, 13, 100, 12, 0, 0, 0, 0, 0, -1, 1));
        kick(8'd1);
        repeat (101) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_end(50);

        // numBlocks=0 sends one block from index 0; start during DATA ignored
        sb.push_back(mk(0, 512, 4096, 512, 1, 1, 16, 4097, 4113, 2, 1));
        kick(8'd0);
        repeat (50) @(posedge clk);
        #1 start = 1'b1; numBlocks = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(20000);

        // reset asserted at CRC slot 5
        sb.push_back(mk(2, 512, 4096, 512, 1, 0, 5, 4097, 0, -1, 1));
        kick(8'd1);
        repeat (4102) @(posedge clk);
        #1 resetCounter = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetCounter = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
